// File: rtl/fdiv16_if.sv
// ============================================================================
// Module      : fdiv16_if
// Description : Start/done handshake and operand/result bundle between the
//               EX stage (master) and the FP16 divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fdiv16_if;
    logic        start;
    logic        flush;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        dz;
    logic        nv;

    modport master (
        output start, flush, op1, op2,
        input  ready, done, result, dz, nv
    );

    modport slave (
        input  start, flush, op1, op2,
        output ready, done, result, dz, nv
    );
endinterface

`default_nettype wire

// File: rtl/fdiv16_seq.sv
// ============================================================================
// Module      : fdiv16_seq
// Description : Multi-cycle FP16 divider, radix-2 restoring mantissa division,
//               truncating, subnormals flushed to signed zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fdiv16_seq #(
    parameter logic [15:0] NAN_CODE = 16'h7E00
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fdiv16_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_DIV   = 2'd2;
    localparam logic [1:0] c_NORM  = 2'd3;

    logic [1:0]  r_state;
    logic [15:0] r_op1;
    logic [15:0] r_op2;
    logic [11:0] r_rem;
    logic [11:0] r_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_result;
    logic        r_dz;
    logic        r_nv;
    logic        r_done;

    logic        w_sign;
    logic        w_zero1, w_inf1, w_nan1;
    logic        w_zero2, w_inf2, w_nan2;
    logic        w_special;
    logic [15:0] w_spec_result;
    logic        w_spec_dz;
    logic        w_spec_nv;
    logic [10:0] w_mb;
    logic        w_ge;
    logic [11:0] w_rem_sub;
    logic signed [6:0] w_e;
    logic [9:0]  w_mant;
    logic [15:0] w_norm_result;

    assign w_sign  = r_op1[15] ^ r_op2[15];
    assign w_zero1 = (r_op1[14:10] == 5'd0);
    assign w_inf1  = (r_op1[14:10] == 5'h1F) && (r_op1[9:0] == 10'd0);
    assign w_nan1  = (r_op1[14:10] == 5'h1F) && (r_op1[9:0] != 10'd0);
    assign w_zero2 = (r_op2[14:10] == 5'd0);
    assign w_inf2  = (r_op2[14:10] == 5'h1F) && (r_op2[9:0] == 10'd0);
    assign w_nan2  = (r_op2[14:10] == 5'h1F) && (r_op2[9:0] != 10'd0);

    // Special-case resolution, highest priority first
    always_comb begin
        w_special     = 1'b1;
        w_spec_dz     = 1'b0;
        w_spec_nv     = 1'b0;
        w_spec_result = {w_sign, 15'h0000};
        if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_spec_result = NAN_CODE;
            w_spec_nv     = 1'b1;
        end else if (w_zero2) begin
            w_spec_result = {w_sign, 5'h1F, 10'h000};
            w_spec_dz     = 1'b1;
        end else if (w_inf1) begin
            w_spec_result = {w_sign, 5'h1F, 10'h000};
        end else if (w_zero1 || w_inf2) begin
            w_spec_result = {w_sign, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // rem stays below 2*mb, so 12 bits never overflow across the shift
    assign w_mb      = {1'b1, r_op2[9:0]};
    assign w_ge      = (r_rem >= {1'b0, w_mb});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, w_mb}) : r_rem;

    assign w_e = $signed({2'b00, r_op1[14:10]}) - $signed({2'b00, r_op2[14:10]})
               + (r_q[11] ? 7'sd15 : 7'sd14);
    assign w_mant = r_q[11] ? r_q[10:1] : r_q[9:0];

    always_comb begin
        if (w_e >= 7'sd31) begin
            w_norm_result = {w_sign, 5'h1F, 10'h000};
        end else if (w_e <= 7'sd0) begin
            w_norm_result = {w_sign, 15'h0000};
        end else begin
            w_norm_result = {w_sign, w_e[4:0], w_mant};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_op1    <= 16'h0000;
            r_op2    <= 16'h0000;
            r_rem    <= 12'h000;
            r_q      <= 12'h000;
            r_cnt    <= 4'd0;
            r_result <= 16'h0000;
            r_dz     <= 1'b0;
            r_nv     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_op1   <= bus.op1;
                        r_op2   <= bus.op2;
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (bus.flush) begin
                        r_state <= c_IDLE;
                    end else if (w_special) begin
                        r_result <= w_spec_result;
                        r_dz     <= w_spec_dz;
                        r_nv     <= w_spec_nv;
                        r_done   <= 1'b1;
                        r_state  <= c_IDLE;
                    end else begin
                        r_rem   <= {1'b0, 1'b1, r_op1[9:0]};
                        r_q     <= 12'h000;
                        r_cnt   <= 4'd0;
                        r_state <= c_DIV;
                    end
                end
                c_DIV: begin
                    if (bus.flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_q   <= {r_q[10:0], w_ge};
                        r_rem <= w_rem_sub << 1;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd11) begin
                            r_state <= c_NORM;
                        end
                    end
                end
                c_NORM: begin
                    if (bus.flush) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_result <= w_norm_result;
                        r_dz     <= 1'b0;
                        r_nv     <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.ready  = (r_state == c_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.dz     = r_dz;
    assign bus.nv     = r_nv;

endmodule

`default_nettype wire

// File: tb/tb_fdiv16_seq.sv
// ============================================================================
// Module      : tb_fdiv16_seq
// Description : Self-checking bench for fdiv16_seq: vector table, random ops
//               against an arithmetic reference, handshake/abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fdiv16_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        dz;
        logic        nv;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    fdiv16_if bus ();

    fdiv16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {special, nv, dz, result} from the FP16 division rules
    function automatic logic [18:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int e1 = int'(a[14:10]);
        int e2 = int'(b[14:10]);
        int m1 = int'(a[9:0]);
        int m2 = int'(b[9:0]);
        logic sg = a[15] ^ b[15];
        bit az = (e1 == 0);
        bit bz = (e2 == 0);
        bit ai = (e1 == 31) && (m1 == 0);
        bit bi = (e2 == 31) && (m2 == 0);
        bit an = (e1 == 31) && (m1 != 0);
        bit bn = (e2 == 31) && (m2 != 0);
        int q, e, mant;
        logic [4:0] e5;
        logic [9:0] m10;
        if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 1'b1, 1'b0, 16'h7E00};
        if (bz) return {1'b1, 1'b0, 1'b1, sg, 15'h7C00};
        if (ai) return {1'b1, 1'b0, 1'b0, sg, 15'h7C00};
        if (az || bi) return {1'b1, 1'b0, 1'b0, sg, 15'h0000};
        q = ((1024 + m1) * 2048) / (1024 + m2);
        if (q >= 2048) begin
            mant = (q / 2) % 1024;
            e    = e1 - e2 + 15;
        end else begin
            mant = q % 1024;
            e    = e1 - e2 + 14;
        end
        if (e >= 31) return {1'b0, 1'b0, 1'b0, sg, 15'h7C00};
        if (e <= 0)  return {1'b0, 1'b0, 1'b0, sg, 15'h0000};
        e5  = e[4:0];
        m10 = mant[9:0];
        return {1'b0, 1'b0, 1'b0, sg, e5, m10};
    endfunction

    function automatic logic [15:0] rand_operand();
        int k = $urandom_range(0, 9);
        logic [15:0] v;
        v = 16'($urandom);
        case (k)
            0: v[14:10] = 5'd0;
            1: begin v[14:10] = 5'h1F; v[9:0] = 10'd0; end
            2: begin v[14:10] = 5'h1F; v[9:0] = 10'($urandom_range(1, 1023)); end
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    // Drives start at the current time (away from an edge) and waits for done
    task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic dz,
                                  output logic nv, output int lat);
        bus.op1   = a;
        bus.op2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = bus.result;
        dz = bus.dz;
        nv = bus.nv;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n++;
        end
    endtask

    vec_t        tbl[14];
    logic [15:0] r;
    logic        dz, nv;
    int          lat, nd, first_done;
    logic [18:0] exp_v;
    logic [15:0] prev;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        tbl[0]  = '{16'h4200, 16'h3E00, 16'h4000, 1'b0, 1'b0, 14};
        tbl[1]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 14};
        tbl[2]  = '{16'hC600, 16'h4000, 16'hC200, 1'b0, 1'b0, 14};
        tbl[3]  = '{16'h4000, 16'h0000, 16'h7C00, 1'b1, 1'b0, 1};
        tbl[4]  = '{16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b1, 1};
        tbl[5]  = '{16'h7BFF, 16'h3800, 16'h7C00, 1'b0, 1'b0, 14};
        tbl[6]  = '{16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b0, 14};
        tbl[7]  = '{16'hFC00, 16'h4000, 16'hFC00, 1'b0, 1'b0, 1};
        tbl[8]  = '{16'h3C00, 16'hFC00, 16'h8000, 1'b0, 1'b0, 1};
        tbl[9]  = '{16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b1, 1};
        tbl[10] = '{16'h7C01, 16'h3C00, 16'h7E00, 1'b0, 1'b1, 1};
        tbl[11] = '{16'hC000, 16'h8000, 16'h7C00, 1'b1, 1'b0, 1};
        tbl[12] = '{16'h7C00, 16'h0000, 16'h7C00, 1'b1, 1'b0, 1};
        tbl[13] = '{16'h0200, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op1   = 16'h0000;
        bus.op2   = 16'h0000;
        #12;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_dz", 32'(bus.dz), 32'd0);
        check("rst_nv", 32'(bus.nv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            start_and_wait(tbl[i].a, tbl[i].b, r, dz, nv, lat);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(tbl[i].r));
            check($sformatf("vec%0d_dz", i), 32'(dz), 32'(tbl[i].dz));
            check($sformatf("vec%0d_nv", i), 32'(nv), 32'(tbl[i].nv));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            a = rand_operand();
            b = rand_operand();
            exp_v = ref_div(a, b);
            start_and_wait(a, b, r, dz, nv, lat);
            check($sformatf("rnd%0d_result(%h/%h)", i, a, b), 32'(r), 32'(exp_v[15:0]));
            check($sformatf("rnd%0d_dz", i), 32'(dz), 32'(exp_v[16]));
            check($sformatf("rnd%0d_nv", i), 32'(nv), 32'(exp_v[17]));
            check($sformatf("rnd%0d_lat", i), 32'(lat), exp_v[18] ? 32'd1 : 32'd14);
            if ((i % 3) == 0) @(negedge clk);
        end

        // Start pulses while busy must be ignored
        @(negedge clk);
        bus.op1   = 16'h4200;
        bus.op2   = 16'h3E00;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op1    = 16'h7BFF;
        bus.op2    = 16'h3800;
        nd         = 0;
        first_done = -1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                nd++;
                if (first_done < 0) first_done = i;
            end
            if (i == 5) check("busy_ready_low", 32'(bus.ready), 32'd0);
            bus.start = (i == 2 || i == 9) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        check("busy_done_count", 32'(nd), 32'd1);
        check("busy_done_cycle", 32'(first_done), 32'd14);
        check("busy_result", 32'(bus.result), 32'h4000);

        // Back-to-back issue in the done cycle
        @(negedge clk);
        start_and_wait(16'hC600, 16'h4000, r, dz, nv, lat);
        check("b2b_first", 32'(r), 32'hC200);
        start_and_wait(16'h3C00, 16'h4200, r, dz, nv, lat);
        check("b2b_second", 32'(r), 32'h3555);
        check("b2b_lat", 32'(lat), 32'd14);
        prev = r;

        // Flush at DIV cycle 5
        @(negedge clk);
        bus.op1   = 16'h4200;
        bus.op2   = 16'h3E00;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("flush_busy", 32'(bus.ready), 32'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.ready), 32'd1);
        count_dones(20, nd);
        check("flush_no_done", 32'(nd), 32'd0);
        check("flush_result_kept", 32'(bus.result), 32'(prev));

        // flush wins over start in IDLE
        bus.op1   = 16'h4200;
        bus.op2   = 16'h3E00;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_ready", 32'(bus.ready), 32'd1);
        count_dones(20, nd);
        check("flush_start_no_done", 32'(nd), 32'd0);

        // Asynchronous reset mid-DIV
        start_and_wait(16'h4000, 16'h0000, r, dz, nv, lat);
        check("pre_rst_dz", 32'(dz), 32'd1);
        @(negedge clk);
        bus.op1   = 16'h4200;
        bus.op2   = 16'h3E00;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.ready), 32'd1);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", 32'(bus.result), 32'h0);
        check("arst_dz", 32'(bus.dz), 32'd0);
        check("arst_nv", 32'(bus.nv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(20, nd);
        check("arst_no_done", 32'(nd), 32'd0);
        start_and_wait(16'hC600, 16'h4000, r, dz, nv, lat);
        check("post_rst_result", 32'(r), 32'hC200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
